uart_loader: RTL and testbench

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader_pkg.sv | 17 +
 rtl/uart_rx.sv | 112 +++++++++++
 rtl/uart_loader.sv | 90 +++++++++
 tb/tb_uart_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// The loader takes 8N1 frames from a serial line and writes them into program memory.
package uart_loader_pkg;

   localparam int unsigned DEF_CLKS_PER_BIT = 104;
   localparam int unsigned DEF_MEM_SIZE     = 512;
   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned STOP_BITS        = 1;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop synchroniser, framing FSM and mid-bit sample timing.
// o_byte_valid and o_frame_err are single-cycle pulses, raised in the cycle of the stop-bit sample.
module uart_rx
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       i_rx,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int unsigned     CNT_W       = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);

   logic [1:0]       sync_q, sync_d;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             wait_high_q, wait_high_d;
   logic             rx_s;

   assign rx_s   = sync_q[1];
   assign o_byte = shift_q;
   assign o_busy = (state_q != RX_IDLE);

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         sync_q      <= '1;
         state_q     <= RX_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         wait_high_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         wait_high_q <= wait_high_d;
      end
   end

   always_comb begin
      sync_d       = {sync_q[0], i_rx};
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      wait_high_d  = wait_high_q;
      o_byte_valid = 1'b0;
      o_frame_err  = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            // After a break the line must return high before a low counts as a start bit.
            if (rx_s) begin
               wait_high_d = 1'b0;
            end else if (!wait_high_q) begin
               state_d = RX_START;
               cnt_d   = HALF_RELOAD;
            end
         end
         RX_START: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rx_s) begin
               state_d = RX_IDLE;
            end else begin
               state_d = RX_DATA;
               cnt_d   = FULL_RELOAD;
               bit_d   = '0;
            end
         end
         RX_DATA: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = FULL_RELOAD;
               if (bit_q == LAST_BIT) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = RX_IDLE;
               if (rx_s) begin
                  o_byte_valid = 1'b1;
               end else begin
                  o_frame_err = 1'b1;
                  wait_high_d = 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives MEM_SIZE bytes over UART and writes them to consecutive addresses.
// o_load_done rises with the final write and holds until reset; later frames are decoded but not written.
module uart_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned MEM_SIZE     = DEF_MEM_SIZE,
   parameter int unsigned ADDR_W       = $clog2(MEM_SIZE)
) (
   input  logic              i_clk,
   input  logic              i_nrst,
   input  logic              i_uart_rx,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_data,
   output logic              o_load_done,
   output logic              o_frame_err,
   output logic              o_busy
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);

   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic              rx_ferr;

   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .i_clk       (i_clk),
      .i_nrst      (i_nrst),
      .i_rx        (i_uart_rx),
      .o_byte      (rx_byte),
      .o_byte_valid(rx_valid),
      .o_frame_err (rx_ferr),
      .o_busy      (o_busy)
   );

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         ptr_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         done_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         done_q <= done_d;
         ferr_q <= ferr_d;
      end
   end

   // The pointer parks on the last address instead of wrapping once loading completes.
   always_comb begin
      ptr_d  = ptr_q;
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      done_d = done_q;
      ferr_d = ferr_q | rx_ferr;
      if (rx_valid && !done_q) begin
         we_d   = 1'b1;
         addr_d = ptr_q;
         data_d = rx_byte;
         if (ptr_q == LAST_ADDR) begin
            done_d = 1'b1;
         end else begin
            ptr_d = ptr_q + ADDR_W'(1);
         end
      end
   end

   assign o_mem_we    = we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_data  = data_q;
   assign o_load_done = done_q;
   assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: vector table, directed corner sequences,
// randomized frames against a byte-level loader model, and a 512-byte load on a second instance.
module tb_uart_loader;
   import uart_loader_pkg::*;

   localparam int unsigned CPB_A      = 4;
   localparam int unsigned MEM_A      = 4;
   localparam int unsigned CPB_B      = 5;
   localparam int unsigned MEM_B      = 512;
   localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       nrst, rx_a, rx_b;
   logic       we_a, done_a, ferr_a, busy_a;
   logic [1:0] addr_a;
   logic [7:0] data_a;
   logic       we_b, done_b, ferr_b, busy_b;
   logic [8:0] addr_b;
   logic [7:0] data_b;

   uart_loader #(.CLKS_PER_BIT(CPB_A), .MEM_SIZE(MEM_A)) dut_a (
      .i_clk(clk), .i_nrst(nrst), .i_uart_rx(rx_a), .o_mem_we(we_a), .o_mem_addr(addr_a),
      .o_mem_data(data_a), .o_load_done(done_a), .o_frame_err(ferr_a), .o_busy(busy_a));

   uart_loader #(.CLKS_PER_BIT(CPB_B), .MEM_SIZE(MEM_B)) dut_b (
      .i_clk(clk), .i_nrst(nrst), .i_uart_rx(rx_b), .o_mem_we(we_b), .o_mem_addr(addr_b),
      .o_mem_data(data_b), .o_load_done(done_b), .o_frame_err(ferr_b), .o_busy(busy_b));

   typedef struct {
      int unsigned addr;
      logic [7:0]  data;
      logic        done;
   } wr_t;

   typedef struct {
      logic [7:0]  d;
      bit          stop;
      bit          exp_we;
      int unsigned exp_addr;
      bit          exp_done;
      bit          exp_ferr;
   } vec_t;

   wr_t act_a[$];
   wr_t act_b[$];
   wr_t exp_a[$];
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   always @(negedge clk) begin
      wr_t w;
      if (we_a) begin
         w.addr = 32'(addr_a); w.data = data_a; w.done = done_a;
         act_a.push_back(w);
      end
      if (we_b) begin
         w.addr = 32'(addr_b); w.data = data_b; w.done = done_b;
         act_b.push_back(w);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit b, input logic v);
      if (b) rx_b = v;
      else   rx_a = v;
   endtask

   task automatic send_frame(input bit b, input logic [7:0] d, input bit stop_ok);
      int unsigned cpb;
      logic [9:0]  bits;
      cpb  = b ? CPB_B : CPB_A;
      bits = {stop_ok, d, 1'b0};
      for (int i = 0; i < int'(FRAME_BITS); i++) begin
         drive(b, bits[i]);
         repeat (cpb) @(negedge clk);
      end
   endtask

   task automatic idle_bits(input bit b, input int unsigned n);
      drive(b, 1'b1);
      repeat (n * (b ? CPB_B : CPB_A)) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      rx_a = 1'b1;
      rx_b = 1'b1;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      act_a.delete();
      act_b.delete();
      exp_a.delete();
      @(negedge clk);
   endtask

   task automatic push_exp_a(input int unsigned addr, input logic [7:0] data, input logic done);
      wr_t w;
      w.addr = addr; w.data = data; w.done = done;
      exp_a.push_back(w);
   endtask

   task automatic check_writes_a(input string tag);
      check({tag, "_count"}, act_a.size(), exp_a.size());
      for (int i = 0; i < act_a.size() && i < exp_a.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), act_a[i].addr, exp_a[i].addr);
         check($sformatf("%s_data%0d", tag, i), 32'(act_a[i].data), 32'(exp_a[i].data));
         check($sformatf("%s_done%0d", tag, i), 32'(act_a[i].done), 32'(exp_a[i].done));
      end
   endtask

   initial begin
      vec_t        tbl[6];
      logic [7:0]  seq4[4];
      int unsigned k;
      int unsigned ptr;
      bit          m_ferr;
      logic [7:0]  d;
      bit          ok;
      logic [7:0]  exp_b[$];

      tbl[0] = '{8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b0};
      tbl[1] = '{8'h3C, 1'b1, 1'b1, 1, 1'b0, 1'b0};
      tbl[2] = '{8'h55, 1'b0, 1'b0, 0, 1'b0, 1'b1};
      tbl[3] = '{8'h12, 1'b1, 1'b1, 2, 1'b0, 1'b1};
      tbl[4] = '{8'hFF, 1'b1, 1'b1, 3, 1'b1, 1'b1};
      tbl[5] = '{8'h77, 1'b1, 1'b0, 0, 1'b1, 1'b1};
      seq4   = '{8'hA5, 8'h3C, 8'h01, 8'hFF};

      rx_a = 1'b1;
      rx_b = 1'b1;
      nrst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_we",   32'(we_a),   0);
      check("rst_addr", 32'(addr_a), 0);
      check("rst_data", 32'(data_a), 0);
      check("rst_done", 32'(done_a), 0);
      check("rst_ferr", 32'(ferr_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      nrst = 1'b1;
      @(negedge clk);

      // Vector table: one frame per entry, outcome checked after two idle bits.
      for (int v = 0; v < 6; v++) begin
         act_a.delete();
         send_frame(0, tbl[v].d, tbl[v].stop);
         idle_bits(0, 2);
         check($sformatf("tbl%0d_we", v), act_a.size(), 32'(tbl[v].exp_we));
         if (act_a.size() == 1 && tbl[v].exp_we) begin
            check($sformatf("tbl%0d_addr", v), act_a[0].addr, tbl[v].exp_addr);
            check($sformatf("tbl%0d_data", v), 32'(act_a[0].data), 32'(tbl[v].d));
         end
         check($sformatf("tbl%0d_done", v), 32'(done_a), 32'(tbl[v].exp_done));
         check($sformatf("tbl%0d_ferr", v), 32'(ferr_a), 32'(tbl[v].exp_ferr));
         check($sformatf("tbl%0d_busy", v), 32'(busy_a), 0);
      end

      // Four clean back-to-back frames fill the memory.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_frame(0, seq4[i], 1'b1);
         push_exp_a(i, seq4[i], i == 3);
      end
      idle_bits(0, 2);
      check_writes_a("clean");
      check("clean_done", 32'(done_a), 1);
      check("clean_ferr", 32'(ferr_a), 0);

      // Single-cycle low glitch on an idle line.
      do_reset();
      rx_a = 1'b0;
      @(negedge clk);
      rx_a = 1'b1;
      k = 0;
      while (!busy_a && k < 8) begin @(negedge clk); k++; end
      check("glitch_busy_seen", 32'(busy_a), 1);
      k = 0;
      while (busy_a && k < CPB_A) begin @(negedge clk); k++; end
      check("glitch_busy_drop", 32'(busy_a), 0);
      idle_bits(0, 2);
      check_writes_a("glitch");
      check("glitch_ferr", 32'(ferr_a), 0);

      // Break: line held low through and past the stop bit, then a normal frame.
      do_reset();
      send_frame(0, 8'h00, 1'b0);
      drive(0, 1'b0);
      repeat (3 * CPB_A) @(negedge clk);
      idle_bits(0, 1);
      send_frame(0, 8'h12, 1'b1);
      idle_bits(0, 2);
      push_exp_a(0, 8'h12, 1'b0);
      check_writes_a("break");
      check("break_ferr", 32'(ferr_a), 1);

      // Reset during the data bits of the second frame.
      do_reset();
      send_frame(0, 8'hC3, 1'b1);
      drive(0, 1'b0);
      repeat (CPB_A) @(negedge clk);
      drive(0, 1'b0); repeat (CPB_A) @(negedge clk);
      drive(0, 1'b1); repeat (CPB_A) @(negedge clk);
      drive(0, 1'b0); repeat (CPB_A) @(negedge clk);
      nrst = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_busy", 32'(busy_a), 0);
      check("midrst_addr", 32'(addr_a), 0);
      check("midrst_data", 32'(data_a), 0);
      rx_a = 1'b1;
      nrst = 1'b1;
      idle_bits(0, 1);
      push_exp_a(0, 8'hC3, 1'b0);
      check_writes_a("midrst_pre");
      act_a.delete();
      exp_a.delete();
      for (int i = 0; i < 4; i++) begin
         send_frame(0, seq4[3 - i], 1'b1);
         push_exp_a(i, seq4[3 - i], i == 3);
      end
      idle_bits(0, 2);
      check_writes_a("midrst_post");
      check("midrst_done", 32'(done_a), 1);

      // Randomized frames against a byte-level model of the loader.
      for (int r = 0; r < 12; r++) begin
         do_reset();
         ptr    = 0;
         m_ferr = 1'b0;
         k      = $urandom_range(3, 7);
         for (int f = 0; f < int'(k); f++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(0, d, ok);
            idle_bits(0, ok ? $urandom_range(0, 2) : $urandom_range(1, 2));
            if (!ok) begin
               m_ferr = 1'b1;
            end else if (ptr < MEM_A) begin
               push_exp_a(ptr, d, ptr == MEM_A - 1);
               ptr++;
            end
         end
         idle_bits(0, 2);
         check_writes_a($sformatf("rnd%0d", r));
         check($sformatf("rnd%0d_done", r), 32'(done_a), 32'(ptr == MEM_A));
         check($sformatf("rnd%0d_ferr", r), 32'(ferr_a), 32'(m_ferr));
      end

      // Full 512-byte back-to-back load on the second instance.
      do_reset();
      for (int i = 0; i < int'(MEM_B); i++) begin
         d = 8'($urandom);
         exp_b.push_back(d);
         send_frame(1, d, 1'b1);
      end
      idle_bits(1, 2);
      check("big_count", act_b.size(), MEM_B);
      for (int i = 0; i < act_b.size() && i < exp_b.size(); i++) begin
         check($sformatf("big_addr%0d", i), act_b[i].addr, i);
         check($sformatf("big_data%0d", i), 32'(act_b[i].data), 32'(exp_b[i]));
         check($sformatf("big_done%0d", i), 32'(act_b[i].done), 32'(i == int'(MEM_B) - 1));
      end
      check("big_done", 32'(done_b), 1);
      check("big_ferr", 32'(ferr_b), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
